// File: rtl/l1_stream_out.sv
// Layer-1 readback: reads N_WORDS words from layer memory and streams them out in raster order
// through a small FIFO. Define L1_STREAM_STAT_EN to build the running max/sum statistics unit.
module l1_stream_out #(
  parameter int          N_WORDS    = 1024,
  parameter logic [2:0]  SEL        = 3'd3,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               crd,
  output logic [11:0]        caddr_rd,
  input  logic signed [19:0] cdata_rd,
  output logic [2:0]         csel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [19:0] out_data,
  output logic [9:0]         out_idx,
  output logic               out_last,
  output logic signed [19:0] stat_max,
  output logic signed [29:0] stat_sum
);

  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam logic [9:0] LAST_IDX = 10'(N_WORDS - 1);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [9:0]         r_idx;
  logic               r_crd;
  logic [11:0]        r_caddr;
  logic signed [19:0] r_fifo_data [FIFO_DEPTH];
  logic [9:0]         r_fifo_idx  [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;

  logic w_start_acc;
  logic w_issue;
  logic w_push;
  logic w_pop;
  logic w_empty;

  assign w_start_acc = start && (r_state == S_IDLE);
  // r_crd doubles as the in-flight flag: the word for an issued read arrives on the next edge
  assign w_issue = (r_state == S_RUN) && ((r_count + {{AW{1'b0}}, r_crd}) < DEPTH_V);
  assign w_push  = r_crd;
  assign w_empty = (r_count == '0);
  assign w_pop   = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_issue && (r_idx == LAST_IDX)) w_state_next = S_DRAIN;
      S_DRAIN: if (!r_crd && w_empty) w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx    <= '0;
      r_crd    <= 1'b0;
      r_caddr  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_start_acc) begin
      r_idx    <= '0;
      r_crd    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_crd <= w_issue;
      if (w_issue) begin
        r_caddr <= {2'b00, r_idx};
        r_idx   <= r_idx + 10'd1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= cdata_rd;
      r_fifo_idx[r_wr_ptr]  <= r_caddr[9:0];
    end
  end

  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign csel      = busy ? SEL : 3'd0;
  assign crd       = r_crd;
  assign caddr_rd  = r_caddr;
  assign out_valid = !w_empty;
  assign out_data  = out_valid ? r_fifo_data[r_rd_ptr] : 20'sd0;
  assign out_idx   = out_valid ? r_fifo_idx[r_rd_ptr] : 10'd0;
  assign out_last  = out_valid && (r_fifo_idx[r_rd_ptr] == LAST_IDX);

`ifdef L1_STREAM_STAT_EN
  logic signed [19:0] r_stat_max;
  logic signed [29:0] r_stat_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset || w_start_acc) begin
      r_stat_max <= 20'sh80000;
      r_stat_sum <= '0;
    end else if (w_pop) begin
      if (out_data > r_stat_max) r_stat_max <= out_data;
      r_stat_sum <= r_stat_sum + {{10{out_data[19]}}, out_data};
    end
  end

  assign stat_max = r_stat_max;
  assign stat_sum = r_stat_sum;
`else
  assign stat_max = '0;
  assign stat_sum = '0;
`endif

endmodule
